falafel_lsu: RTL and testbench

Load/store unit serving the falafel allocator core: accepts one header/lock request at a time from the core, turns it into word-level accesses on a single-port memory bus, and returns a one-cycle response. It sits between the allocator core's `req_to_lsu`/`rsp_from_lsu` interface and the heap memory that holds the free-list headers and the allocator lock word.

---
 rtl/falafel_lsu_if.sv | 60 ++++++
 rtl/falafel_lsu.sv | 236 +++++++++++++++++++++++
 tb/tb_falafel_lsu.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/falafel_lsu_if.sv
// Shared types and the bundled core/memory bus of the falafel load/store unit.
package falafel_lsu_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_LOCK   = 3'd0,
    OP_UNLOCK = 3'd1,
    OP_LOAD   = 3'd2,
    OP_INSERT = 3'd3,
    OP_DELETE = 3'd4
  } lsu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] size;
    logic [DATA_W-1:0] next_addr;
  } header_data_t;

  typedef struct packed {
    logic         val;
    lsu_op_e      lsu_op;
    header_data_t header_data;
  } header_data_req_t;

  typedef struct packed {
    logic         val;
    header_data_t header_data;
  } header_data_rsp_t;

endpackage

// Core request/response plus single-port memory bus. The master view is the LSU;
// the slave view is the environment (allocator core and heap memory).
interface falafel_lsu_if;
  import falafel_lsu_pkg::*;

  header_data_req_t    req_i;
  logic                lsu_ready_o;
  header_data_rsp_t    rsp_o;
  logic                mem_req_o;
  logic                mem_gnt_i;
  logic                mem_we_o;
  logic                mem_lock_o;
  logic [DATA_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_wdata_o;
  logic                mem_rvalid_i;
  logic [DATA_W-1:0]   mem_rdata_i;

  modport master (
    input  req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output lsu_ready_o, rsp_o, mem_req_o, mem_we_o, mem_lock_o, mem_addr_o, mem_wdata_o
  );

  modport slave (
    output req_i, mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  lsu_ready_o, rsp_o, mem_req_o, mem_we_o, mem_lock_o, mem_addr_o, mem_wdata_o
  );

endinterface

// File: rtl/falafel_lsu.sv
// falafel_lsu: turns one allocator header/lock request at a time into word
// accesses on a single-port memory and returns a one-cycle response.
// Every output is a register written on the transition into the state that
// owns it, so nothing combinational runs from req_i to the outputs.
module falafel_lsu
  import falafel_lsu_pkg::*;
#(
  parameter logic [DATA_W-1:0] LOCK_ADDR   = '0,
  parameter int unsigned       WORD_BYTES  = DATA_W / 8,
  parameter int unsigned       RETRY_DELAY = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  falafel_lsu_if.master bus
);

  localparam int                CNT_W    = $clog2(RETRY_DELAY + 1);
  localparam logic [DATA_W-1:0] WORD_OFS = DATA_W'(WORD_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_RD_SIZE, S_WAIT_SIZE, S_RD_NEXT, S_WAIT_NEXT, S_WR_SIZE, S_WR_NEXT,
    S_LOCK_RD, S_LOCK_WAIT, S_LOCK_BACKOFF, S_LOCK_WR, S_UNLOCK_WR, S_RSP
  } state_e;

  state_e              state_q;
  header_data_t        hdr_q;        // header latched at acceptance
  logic [DATA_W-1:0]   size_rd_q;    // size word returned by the first LOAD read
  logic [CNT_W-1:0]    backoff_q;    // remaining idle cycles before a lock retry
  logic                lsu_ready_q;
  header_data_rsp_t    rsp_q;
  logic                mem_req_q;
  logic                mem_we_q;
  logic                mem_lock_q;
  logic [DATA_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  assign bus.lsu_ready_o = lsu_ready_q;
  assign bus.rsp_o       = rsp_q;
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_lock_o  = mem_lock_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;

  // Sequencer: state plus registered bus/response outputs for the state being entered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      hdr_q       <= '0;
      size_rd_q   <= '0;
      backoff_q   <= '0;
      lsu_ready_q <= 1'b1;
      rsp_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_lock_q  <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_i.val) begin
            hdr_q       <= bus.req_i.header_data;
            lsu_ready_q <= 1'b0;
            case (bus.req_i.lsu_op)
              OP_LOAD: begin
                state_q    <= S_RD_SIZE;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_addr_q <= bus.req_i.header_data.addr;
              end
              OP_INSERT: begin
                state_q     <= S_WR_SIZE;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= bus.req_i.header_data.addr;
                mem_wdata_q <= bus.req_i.header_data.size;
              end
              OP_DELETE: begin
                // Only the link word changes: the predecessor now points past us.
                state_q     <= S_WR_NEXT;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= bus.req_i.header_data.addr + WORD_OFS;
                mem_wdata_q <= bus.req_i.header_data.next_addr;
              end
              OP_LOCK: begin
                state_q    <= S_LOCK_RD;
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_lock_q <= 1'b1;
                mem_addr_q <= LOCK_ADDR;
              end
              OP_UNLOCK: begin
                state_q     <= S_UNLOCK_WR;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b1;
                mem_addr_q  <= LOCK_ADDR;
                mem_wdata_q <= '0;
              end
              default: begin
                // Unknown op: answer straight away with an empty header.
                state_q           <= S_RSP;
                rsp_q.val         <= 1'b1;
                rsp_q.header_data <= '0;
              end
            endcase
          end
        end

        S_RD_SIZE: begin
          if (bus.mem_gnt_i) begin
            state_q   <= S_WAIT_SIZE;
            mem_req_q <= 1'b0;
          end
        end

        S_WAIT_SIZE: begin
          if (bus.mem_rvalid_i) begin
            state_q    <= S_RD_NEXT;
            size_rd_q  <= bus.mem_rdata_i;
            mem_req_q  <= 1'b1;
            mem_addr_q <= hdr_q.addr + WORD_OFS;
          end
        end

        S_RD_NEXT: begin
          if (bus.mem_gnt_i) begin
            state_q   <= S_WAIT_NEXT;
            mem_req_q <= 1'b0;
          end
        end

        S_WAIT_NEXT: begin
          if (bus.mem_rvalid_i) begin
            state_q                     <= S_RSP;
            rsp_q.val                   <= 1'b1;
            rsp_q.header_data.addr      <= hdr_q.addr;
            rsp_q.header_data.size      <= size_rd_q;
            rsp_q.header_data.next_addr <= bus.mem_rdata_i;
          end
        end

        S_WR_SIZE: begin
          if (bus.mem_gnt_i) begin
            state_q     <= S_WR_NEXT;
            mem_addr_q  <= hdr_q.addr + WORD_OFS;
            mem_wdata_q <= hdr_q.next_addr;
          end
        end

        S_WR_NEXT: begin
          if (bus.mem_gnt_i) begin
            state_q           <= S_RSP;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            rsp_q.val         <= 1'b1;
            rsp_q.header_data <= hdr_q;
          end
        end

        S_LOCK_RD: begin
          if (bus.mem_gnt_i) begin
            state_q   <= S_LOCK_WAIT;
            mem_req_q <= 1'b0;
          end
        end

        S_LOCK_WAIT: begin
          if (bus.mem_rvalid_i) begin
            if (bus.mem_rdata_i != '0) begin
              // Lock is held elsewhere: release the bus while we wait.
              state_q    <= S_LOCK_BACKOFF;
              mem_lock_q <= 1'b0;
              backoff_q  <= CNT_W'(RETRY_DELAY - 1);
            end else begin
              state_q     <= S_LOCK_WR;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= DATA_W'(1);
            end
          end
        end

        S_LOCK_BACKOFF: begin
          if (backoff_q == '0) begin
            state_q    <= S_LOCK_RD;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_lock_q <= 1'b1;
            mem_addr_q <= LOCK_ADDR;
          end else begin
            backoff_q <= backoff_q - 1'b1;
          end
        end

        S_LOCK_WR: begin
          if (bus.mem_gnt_i) begin
            state_q           <= S_RSP;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            mem_lock_q        <= 1'b0;
            rsp_q.val         <= 1'b1;
            rsp_q.header_data <= '0;
          end
        end

        S_UNLOCK_WR: begin
          if (bus.mem_gnt_i) begin
            state_q           <= S_RSP;
            mem_req_q         <= 1'b0;
            mem_we_q          <= 1'b0;
            rsp_q.val         <= 1'b1;
            rsp_q.header_data <= '0;
          end
        end

        S_RSP: begin
          state_q     <= S_IDLE;
          rsp_q       <= '0;
          lsu_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= S_IDLE;
          rsp_q       <= '0;
          lsu_ready_q <= 1'b1;
          mem_req_q   <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_lock_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_falafel_lsu.sv
// Randomized bench for falafel_lsu: a behavioural heap memory with random
// grant/rvalid stalls, and a per-operation reference of accesses, response
// and latency derived from the operation rules.
`timescale 1ns/1ps
module tb_falafel_lsu;
  import falafel_lsu_pkg::*;

  localparam int                RD    = 3;
  localparam logic [DATA_W-1:0] LADDR = '0;
  localparam logic [DATA_W-1:0] WB    = 32'd4;

  typedef struct packed {
    logic              lock;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  falafel_lsu_if bus();

  falafel_lsu #(.LOCK_ADDR(LADDR), .WORD_BYTES(4), .RETRY_DELAY(RD)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- heap memory model ----------------
  logic [DATA_W-1:0] tb_mem [logic [DATA_W-1:0]];
  acc_t              acc_log[$];
  int                stall_mode = 0;   // <0 random 0..2, else fixed grant stall
  int                rv_mode    = 0;   // <0 random 0..2, else fixed extra rvalid delay
  int                stalls_acc = 0;   // stall cycles inserted during the current op
  int                fail_left  = 0;   // lock reads still to return "busy"
  bit                force_rv   = 1'b0;
  bit                in_acc     = 1'b0;
  bit                was_stalled;
  int                stall_left;
  int                rv_cnt     = 0;
  int                extra;
  logic [DATA_W-1:0] rv_data;
  acc_t              cur, first;

  function automatic logic [DATA_W-1:0] rd(input logic [DATA_W-1:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : '0;
  endfunction

  function automatic acc_t mk(input logic l, input logic w, input logic [DATA_W-1:0] a,
                              input logic [DATA_W-1:0] d);
    acc_t r;
    r.lock = l; r.we = w; r.addr = a; r.wdata = d;
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    if (rst) begin
      in_acc = 1'b0;
      rv_cnt = 0;
    end else begin
      if (force_rv) begin
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = $urandom;
        force_rv         = 1'b0;
      end
      if (rv_cnt > 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = rv_data;
        end
      end
      if (bus.mem_req_o) begin
        cur = mk(bus.mem_lock_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o);
        if (!in_acc) begin
          in_acc      = 1'b1;
          first       = cur;
          stall_left  = (stall_mode < 0) ? int'($urandom_range(0, 2)) : stall_mode;
          stalls_acc += stall_left;
          was_stalled = (stall_left > 0);
        end
        if (stall_left == 0) begin
          bus.mem_gnt_i = 1'b1;
          in_acc        = 1'b0;
          if (was_stalled) chk("hold_stable", 128'(cur), 128'(first));
          if (cur.we) begin
            tb_mem[cur.addr] = cur.wdata;
          end else begin
            extra       = (rv_mode < 0) ? int'($urandom_range(0, 2)) : rv_mode;
            stalls_acc += extra;
            rv_cnt      = 1 + extra;
            if (cur.addr == LADDR && fail_left > 0) begin
              rv_data = $urandom | 32'd1;
              fail_left--;
            end else begin
              rv_data = rd(cur.addr);
            end
            cur.wdata = '0;
          end
          acc_log.push_back(cur);
        end else begin
          stall_left--;
        end
      end else if (stall_mode < 0 && $urandom_range(0, 3) == 0) begin
        bus.mem_gnt_i = 1'b1;   // stray grant, must be ignored
      end
    end
  end

  // ---------------- one operation against the reference ----------------
  task automatic run_op(input logic [2:0] op, input header_data_t h, input bit hold, input int nfail);
    acc_t              exp_q[$];
    header_data_t      exp_h;
    logic [DATA_W-1:0] a1;
    int base, t0, exp_lat, waited;
    int lat, pulses, lock_hi, ready_hi;
    string nm;
    lat = -1; pulses = 0; lock_hi = 0; ready_hi = 0; waited = 0;
    nm    = $sformatf("op%0d@%0h", op, h.addr);
    a1    = h.addr + WB;
    exp_h = '0;
    case (op)
      3'd2: begin
        base = 5;
        exp_q.push_back(mk(1'b0, 1'b0, h.addr, '0));
        exp_q.push_back(mk(1'b0, 1'b0, a1, '0));
        exp_h.addr = h.addr; exp_h.size = rd(h.addr); exp_h.next_addr = rd(a1);
      end
      3'd3: begin
        base = 3;
        exp_q.push_back(mk(1'b0, 1'b1, h.addr, h.size));
        exp_q.push_back(mk(1'b0, 1'b1, a1, h.next_addr));
        exp_h = h;
      end
      3'd4: begin
        base = 2;
        exp_q.push_back(mk(1'b0, 1'b1, a1, h.next_addr));
        exp_h = h;
      end
      3'd0: begin
        base = 4 + nfail * (2 + RD);
        for (int i = 0; i <= nfail; i++) exp_q.push_back(mk(1'b1, 1'b0, LADDR, '0));
        exp_q.push_back(mk(1'b1, 1'b1, LADDR, 32'd1));
        tb_mem[LADDR] = '0;
      end
      3'd1: begin
        base = 2;
        exp_q.push_back(mk(1'b0, 1'b1, LADDR, '0));
      end
      default: base = 1;
    endcase
    fail_left = (op == 3'd0) ? nfail : 0;

    while (bus.lsu_ready_o !== 1'b1 && waited < 50) begin
      @(posedge clk); #2;
      waited++;
    end
    if (waited >= 50) chk({nm, "_ready_timeout"}, 128'(bus.lsu_ready_o), 128'(1));

    bus.req_i.val         = 1'b1;
    bus.req_i.lsu_op      = lsu_op_e'(op);
    bus.req_i.header_data = h;
    acc_log.delete();
    stalls_acc = 0;
    t0 = cyc;

    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #2;
      if (lat < 0 && !hold) begin
        bus.req_i.val         = 1'b0;
        bus.req_i.lsu_op      = lsu_op_e'(3'($urandom));
        bus.req_i.header_data = {$urandom, $urandom, $urandom};
      end
      if (bus.rsp_o.val) pulses++;
      if (lat < 0) begin
        if (bus.mem_lock_o) lock_hi++;
        if (bus.lsu_ready_o) ready_hi++;
      end
      if (lat < 0 && bus.rsp_o.val) begin
        lat = cyc - t0;
        chk({nm, "_rsp"}, 128'(bus.rsp_o.header_data), 128'(exp_h));
      end else if (lat >= 0 && cyc == t0 + lat + 1) begin
        chk({nm, "_ready_after"}, 128'(bus.lsu_ready_o), 128'(1));
        if (hold) bus.req_i.val = 1'b0;
      end
      if (lat >= 0 && cyc == t0 + lat + 2) break;
    end
    bus.req_i.val = 1'b0;

    exp_lat = base + stalls_acc;
    chk({nm, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({nm, "_pulses"}, 128'(pulses), 128'(1));
    chk({nm, "_ready_busy"}, 128'(ready_hi), 128'(0));
    chk({nm, "_nacc"}, 128'(acc_log.size()), 128'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < acc_log.size(); i++)
      chk($sformatf("%s_acc%0d", nm, i), 128'(acc_log[i]), 128'(exp_q[i]));
    if (op == 3'd0) chk({nm, "_lock_cycles"}, 128'(lock_hi), 128'(exp_lat - 1 - nfail * RD));
    chk({nm, "_lock_end"}, 128'(bus.mem_lock_o), 128'(0));
  endtask

  task automatic rst_test();
    int t0, pulses;
    pulses = 0;
    stall_mode = 0; rv_mode = 0;
    tb_mem[32'h300] = 32'd5;
    tb_mem[32'h304] = 32'd6;
    bus.req_i.val              = 1'b1;
    bus.req_i.lsu_op           = OP_LOAD;
    bus.req_i.header_data      = '0;
    bus.req_i.header_data.addr = 32'h300;
    t0 = cyc;
    @(posedge clk); #2;
    bus.req_i.val = 1'b0;
    while (cyc < t0 + 4) begin @(posedge clk); #2; end
    chk("rst_pre_addr", 128'(bus.mem_addr_o), 128'(32'h304));
    #1 rst = 1'b1;
    #1;
    chk("rst_async_ready", 128'(bus.lsu_ready_o), 128'(1));
    chk("rst_async_req", 128'(bus.mem_req_o), 128'(0));
    chk("rst_async_rsp", 128'(bus.rsp_o), 128'(0));
    chk("rst_async_addr", 128'(bus.mem_addr_o), 128'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    force_rv = 1'b1;
    repeat (5) begin
      @(posedge clk); #2;
      if (bus.rsp_o.val) pulses++;
    end
    chk("rst_late_rvalid_pulses", 128'(pulses), 128'(0));
    chk("rst_ready_after", 128'(bus.lsu_ready_o), 128'(1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  header_data_t hd;

  initial begin
    bus.req_i        = '0;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_ready", 128'(bus.lsu_ready_o), 128'(1));
    chk("reset_rsp", 128'(bus.rsp_o), 128'(0));
    chk("reset_req", 128'(bus.mem_req_o), 128'(0));
    chk("reset_we", 128'(bus.mem_we_o), 128'(0));
    chk("reset_lock", 128'(bus.mem_lock_o), 128'(0));
    chk("reset_addr", 128'(bus.mem_addr_o), 128'(0));
    chk("reset_wdata", 128'(bus.mem_wdata_o), 128'(0));
    rst = 1'b0;
    @(posedge clk); #2;

    // directed: LOAD
    stall_mode = 0; rv_mode = 0;
    tb_mem[32'h10] = 32'd200;
    tb_mem[32'h14] = 32'h80;
    hd = '0; hd.addr = 32'h10;
    run_op(3'd2, hd, 1'b0, 0);
    // directed: INSERT with 2-cycle grant stalls
    stall_mode = 2;
    hd.addr = 32'h120; hd.size = 32'd96; hd.next_addr = 32'h0;
    run_op(3'd3, hd, 1'b0, 0);
    stall_mode = 0;
    // directed: DELETE
    hd.addr = 32'h10; hd.size = 32'd7; hd.next_addr = 32'h200;
    run_op(3'd4, hd, 1'b0, 0);
    // directed: LOCK failing twice
    run_op(3'd0, '0, 1'b0, 2);
    // directed: UNLOCK with req held through the response
    run_op(3'd1, '0, 1'b1, 0);
    // directed: illegal op
    run_op(3'd7, hd, 1'b0, 0);
    // directed: header whose link word wraps past the top of memory
    hd.addr = 32'hFFFF_FFFC;
    run_op(3'd2, hd, 1'b0, 0);
    // reset in WAIT_NEXT
    rst_test();

    // randomized
    stall_mode = -1; rv_mode = -1;
    for (int n = 0; n < 60; n++) begin
      hd.addr      = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : 32'h100 + (32'($urandom_range(0, 15)) << 4);
      hd.size      = $urandom;
      hd.next_addr = $urandom;
      run_op(3'($urandom_range(0, 7)), hd, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
